// File: rtl/biriscv_pipe_ctrl_nstage_pkg.sv
// Shared field layout for the execute/commit pipeline tracker: exception width,
// the interrupt cause code and the bit positions of one packed stage entry.
package biriscv_pipe_ctrl_nstage_pkg;

    localparam int EXCEPTION_W = 6;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_INTERRUPT = 6'h20;

    // Packed entry, LSB first: valid, late, ready, rd[5], pc[32], result[32], exc[EXC_W]
    localparam int ENTRY_VALID      = 0;
    localparam int ENTRY_LATE       = 1;
    localparam int ENTRY_READY      = 2;
    localparam int ENTRY_RD_LSB     = 3;
    localparam int ENTRY_PC_LSB     = 8;
    localparam int ENTRY_RESULT_LSB = 40;
    localparam int ENTRY_EXC_LSB    = 72;

    function automatic int entry_w(input int exc_w);
        return ENTRY_EXC_LSB + exc_w;
    endfunction

endpackage

// File: rtl/biriscv_pipe_stage_reg.sv
// One pipeline stage register: clear beats load, load beats hold.
module biriscv_pipe_stage_reg #(
    parameter int W = 78
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/biriscv_pipe_ctrl_nstage.sv
// In-order E1..WB pipeline tracker with late-result merge, squash and operand bypass lookup.
// Optional retired-instruction counter enabled by defining BIRISCV_PIPE_RETIRE_CNT_EN.
module biriscv_pipe_ctrl_nstage
    import biriscv_pipe_ctrl_nstage_pkg::*;
#(
    parameter int STAGES       = 3,
    parameter int RESULT_STAGE = 2,
    parameter int EXC_W        = EXCEPTION_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic [4:0]       issue_rd_i,
    input  logic             issue_late_i,
    input  logic [31:0]      issue_result_i,
    input  logic [31:0]      issue_pc_i,
    input  logic [EXC_W-1:0] issue_exception_i,
    input  logic             late_valid_i,
    input  logic [31:0]      late_result_i,
    input  logic [EXC_W-1:0] late_exception_i,
    input  logic             squash_i,
    input  logic [4:0]       ra_i,
    input  logic [4:0]       rb_i,
    output logic             hazard_o,
    output logic             byp_ra_valid_o,
    output logic [31:0]      byp_ra_o,
    output logic             byp_rb_valid_o,
    output logic [31:0]      byp_rb_o,
    output logic             stall_o,
    output logic             squash_o,
    output logic             wb_valid_o,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_result_o,
    output logic [31:0]      wb_pc_o,
    output logic [EXC_W-1:0] wb_exception_o,
    output logic [31:0]      retire_count_o
);

    localparam int W = entry_w(EXC_W);
    localparam int R = RESULT_STAGE;

    logic [W-1:0]  stage_q [1:STAGES];
    logic [W-1:0]  stage_d [1:STAGES];
    logic [STAGES:1] s_valid;
    logic [STAGES:1] s_ready;
    logic [4:0]    s_rd     [1:STAGES];
    logic [31:0]   s_result [1:STAGES];

    logic             r_wait, merge, exc_hit, insert, squash_q;
    logic [EXC_W-1:0] r_exc;
    logic [W-1:0]     r_fwd, issue_entry;
    logic             unused_wb_late;

    assign r_wait  = stage_q[R][ENTRY_VALID] & stage_q[R][ENTRY_LATE] & ~stage_q[R][ENTRY_READY];
    assign merge   = r_wait & late_valid_i;
    assign stall_o = r_wait & ~late_valid_i;
    assign r_exc   = stage_q[R][ENTRY_EXC_LSB +: EXC_W];

    // Build the RESULT_STAGE entry as it leaves, with any late result/fault merged in
    always_comb begin
        r_fwd   = stage_q[R];
        exc_hit = 1'b0;
        if (merge) begin
            r_fwd[ENTRY_READY]                 = 1'b1;
            r_fwd[ENTRY_RESULT_LSB +: 32]      = late_result_i;
            if (r_exc == '0)
                r_fwd[ENTRY_EXC_LSB +: EXC_W]  = late_exception_i;
        end
        exc_hit = stage_q[R][ENTRY_VALID] & ~stall_o & (r_fwd[ENTRY_EXC_LSB +: EXC_W] != '0);
        if (exc_hit)
            r_fwd[ENTRY_RD_LSB +: 5] = 5'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            squash_q <= 1'b0;
        else
            squash_q <= exc_hit;
    end

    assign squash_o = exc_hit | squash_q;
    assign insert   = issue_valid_i & ~stall_o & ~squash_o & ~squash_i;

    always_comb begin
        issue_entry = '0;
        if (insert) begin
            issue_entry[ENTRY_VALID]              = 1'b1;
            issue_entry[ENTRY_LATE]               = issue_late_i;
            issue_entry[ENTRY_READY]              = ~issue_late_i;
            issue_entry[ENTRY_RD_LSB +: 5]        = issue_rd_i;
            issue_entry[ENTRY_PC_LSB +: 32]       = issue_pc_i;
            issue_entry[ENTRY_RESULT_LSB +: 32]   = issue_result_i;
            issue_entry[ENTRY_EXC_LSB +: EXC_W]   = issue_exception_i;
        end
    end

    // On a fault everything younger than the faulting entry is discarded, so stages 2..R take bubbles
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        if (k == 1) begin : g_first
            assign stage_d[k] = issue_entry;
        end else if (k <= R) begin : g_young
            assign stage_d[k] = exc_hit ? '0 : stage_q[k-1];
        end else if (k == R + 1) begin : g_merge
            assign stage_d[k] = r_fwd;
        end else begin : g_old
            assign stage_d[k] = stage_q[k-1];
        end

        biriscv_pipe_stage_reg #(.W(W)) u_reg (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .load  (~stall_o),
            .clear (squash_i),
            .d     (stage_d[k]),
            .q     (stage_q[k])
        );

        assign s_valid[k]  = stage_q[k][ENTRY_VALID];
        assign s_ready[k]  = stage_q[k][ENTRY_READY];
        assign s_rd[k]     = stage_q[k][ENTRY_RD_LSB +: 5];
        assign s_result[k] = stage_q[k][ENTRY_RESULT_LSB +: 32];
    end

    // Lookup chain runs oldest to youngest so the youngest matching stage wins
    logic [4:0]  op    [2];
    logic        hit_c [2][1:STAGES+1];
    logic        rdy_c [2][1:STAGES+1];
    logic [31:0] val_c [2][1:STAGES+1];

    assign op[0] = ra_i;
    assign op[1] = rb_i;

    for (genvar o = 0; o < 2; o++) begin : g_op
        assign hit_c[o][STAGES+1] = 1'b0;
        assign rdy_c[o][STAGES+1] = 1'b0;
        assign val_c[o][STAGES+1] = '0;
        for (genvar k = 1; k <= STAGES; k++) begin : g_lk
            localparam bit IS_R = (k == RESULT_STAGE);
            logic m;
            assign m           = s_valid[k] & (s_rd[k] == op[o]) & (op[o] != 5'd0);
            assign hit_c[o][k] = m | hit_c[o][k+1];
            assign rdy_c[o][k] = m ? (s_ready[k] | (IS_R & late_valid_i)) : rdy_c[o][k+1];
            assign val_c[o][k] = m ? (s_ready[k] ? s_result[k] : late_result_i) : val_c[o][k+1];
        end
    end

    assign byp_ra_valid_o = hit_c[0][1] & rdy_c[0][1];
    assign byp_rb_valid_o = hit_c[1][1] & rdy_c[1][1];
    assign byp_ra_o       = byp_ra_valid_o ? val_c[0][1] : '0;
    assign byp_rb_o       = byp_rb_valid_o ? val_c[1][1] : '0;
    assign hazard_o       = (hit_c[0][1] & ~rdy_c[0][1]) | (hit_c[1][1] & ~rdy_c[1][1]);

    assign wb_valid_o     = s_valid[STAGES] & ~stall_o;
    assign wb_rd_o        = wb_valid_o ? s_rd[STAGES] : 5'd0;
    assign wb_result_o    = s_result[STAGES];
    assign wb_pc_o        = stage_q[STAGES][ENTRY_PC_LSB +: 32];
    assign wb_exception_o = stage_q[STAGES][ENTRY_EXC_LSB +: EXC_W];
    assign unused_wb_late = stage_q[STAGES][ENTRY_LATE];

`ifdef BIRISCV_PIPE_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            retire_q <= '0;
        else if (wb_valid_o && (wb_exception_o == '0))
            retire_q <= retire_q + 32'd1;
    end

    assign retire_count_o = retire_q;
`else
    assign retire_count_o = '0;
`endif

endmodule

// File: tb/tb_biriscv_pipe_ctrl_nstage.sv
// Directed bench for biriscv_pipe_ctrl_nstage (STAGES=3, RESULT_STAGE=2) with a commit scoreboard.
module tb_biriscv_pipe_ctrl_nstage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic        issue_late_i = 1'b0;
    logic [31:0] issue_result_i = '0;
    logic [31:0] issue_pc_i = '0;
    logic [5:0]  issue_exception_i = '0;
    logic        late_valid_i = 1'b0;
    logic [31:0] late_result_i = '0;
    logic [5:0]  late_exception_i = '0;
    logic        squash_i = 1'b0;
    logic [4:0]  ra_i = '0;
    logic [4:0]  rb_i = '0;
    logic        hazard_o, byp_ra_valid_o, byp_rb_valid_o, stall_o, squash_o, wb_valid_o;
    logic [31:0] byp_ra_o, byp_rb_o, wb_result_o, wb_pc_o, retire_count_o;
    logic [4:0]  wb_rd_o;
    logic [5:0]  wb_exception_o;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] pc;
        logic [5:0]  exc;
    } commit_t;

    commit_t     exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retire = '0;

    biriscv_pipe_ctrl_nstage #(.STAGES(3), .RESULT_STAGE(2), .EXC_W(6)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_rd_i        (issue_rd_i),
        .issue_late_i      (issue_late_i),
        .issue_result_i    (issue_result_i),
        .issue_pc_i        (issue_pc_i),
        .issue_exception_i (issue_exception_i),
        .late_valid_i      (late_valid_i),
        .late_result_i     (late_result_i),
        .late_exception_i  (late_exception_i),
        .squash_i          (squash_i),
        .ra_i              (ra_i),
        .rb_i              (rb_i),
        .hazard_o          (hazard_o),
        .byp_ra_valid_o    (byp_ra_valid_o),
        .byp_ra_o          (byp_ra_o),
        .byp_rb_valid_o    (byp_rb_valid_o),
        .byp_rb_o          (byp_rb_o),
        .stall_o           (stall_o),
        .squash_o          (squash_o),
        .wb_valid_o        (wb_valid_o),
        .wb_rd_o           (wb_rd_o),
        .wb_result_o       (wb_result_o),
        .wb_pc_o           (wb_pc_o),
        .wb_exception_o    (wb_exception_o),
        .retire_count_o    (retire_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive just after the rising edge, return at the falling edge
    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic late,
                                 input logic [31:0] res, input logic [31:0] pc,
                                 input logic lv, input logic [31:0] lres, input logic [5:0] lexc,
                                 input logic sq, input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk_i);
        #1;
        issue_valid_i    = v;
        issue_rd_i       = rd;
        issue_late_i     = late;
        issue_result_i   = res;
        issue_pc_i       = pc;
        late_valid_i     = lv;
        late_result_i    = lres;
        late_exception_i = lexc;
        squash_i         = sq;
        ra_i             = ra;
        rb_i             = rb;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expectCommit(input logic [4:0] rd, input logic [31:0] res,
                                input logic [31:0] pc, input logic [5:0] exc);
        commit_t c;
        c.rd = rd; c.result = res; c.pc = pc; c.exc = exc;
        exp_q.push_back(c);
    endtask

    // Scoreboard monitor: every commit must match the oldest expected entry
    always @(negedge clk_i) begin
        if (!rst_i && wb_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL commit unexpected rd=%0d pc=%h actual=commit required=none",
                         wb_rd_o, wb_pc_o);
            end else begin
                commit_t c;
                c = exp_q.pop_front();
                if (wb_rd_o !== c.rd || wb_result_o !== c.result ||
                    wb_pc_o !== c.pc || wb_exception_o !== c.exc) begin
                    errors++;
                    $display("[TB] FAIL commit actual rd=%0d res=%h pc=%h exc=%0d required rd=%0d res=%h pc=%h exc=%0d",
                             wb_rd_o, wb_result_o, wb_pc_o, wb_exception_o,
                             c.rd, c.result, c.pc, c.exc);
                end
`ifdef BIRISCV_PIPE_RETIRE_CNT_EN
                if (c.exc == 6'd0)
                    exp_retire = exp_retire + 32'd1;
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_wb_valid", {31'd0, wb_valid_o}, 0);
        checkOutput("reset_wb_pc", wb_pc_o, 0);
        checkOutput("reset_stall", {31'd0, stall_o}, 0);
        checkOutput("reset_squash", {31'd0, squash_o}, 0);
        checkOutput("reset_hazard", {31'd0, hazard_o}, 0);
        checkOutput("reset_retire", retire_count_o, 0);
        idle(2);

        // ALU writer: bypass while in flight, commit two cycles after it sits in E1
        expectCommit(5, 32'h1234, 32'h100, 0);
        applyStimulus(1, 5, 0, 32'h1234, 32'h100, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("alu_byp_valid", {31'd0, byp_ra_valid_o}, 1);
        checkOutput("alu_byp_value", byp_ra_o, 32'h1234);
        checkOutput("alu_hazard", {31'd0, hazard_o}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_wb_early", {31'd0, wb_valid_o}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_wb_valid", {31'd0, wb_valid_o}, 1);
        checkOutput("alu_wb_rd", {27'd0, wb_rd_o}, 5);
        idle(3);

        // Late writer: four stalled cycles, then late result bypassed and committed once
        expectCommit(7, 32'hBEEF, 32'h200, 0);
        applyStimulus(1, 7, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        checkOutput("late_e1_hazard", {31'd0, hazard_o}, 1);
        checkOutput("late_e1_stall", {31'd0, stall_o}, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
            checkOutput($sformatf("late_stall_%0d", i), {31'd0, stall_o}, 1);
            checkOutput($sformatf("late_hazard_%0d", i), {31'd0, hazard_o}, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hBEEF, 0, 0, 7, 0);
        checkOutput("late_arrive_stall", {31'd0, stall_o}, 0);
        checkOutput("late_arrive_byp_valid", {31'd0, byp_ra_valid_o}, 1);
        checkOutput("late_arrive_byp", byp_ra_o, 32'hBEEF);
        checkOutput("late_arrive_hazard", {31'd0, hazard_o}, 0);
        idle(4);

        // Late fault: younger entries dropped, faulting entry commits with rd=0
        expectCommit(0, 32'h55, 32'h300, 5);
        applyStimulus(1, 9, 1, 0, 32'h300, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 10, 0, 32'hA, 32'h304, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 11, 0, 32'hB, 32'h308, 1, 32'h55, 6'd5, 0, 0, 0);
        checkOutput("fault_squash_0", {31'd0, squash_o}, 1);
        checkOutput("fault_stall", {31'd0, stall_o}, 0);
        applyStimulus(1, 12, 0, 32'hC, 32'h30C, 0, 0, 0, 0, 0, 0);
        checkOutput("fault_squash_1", {31'd0, squash_o}, 1);
        checkOutput("fault_wb_valid", {31'd0, wb_valid_o}, 1);
        checkOutput("fault_wb_rd", {27'd0, wb_rd_o}, 0);
        checkOutput("fault_wb_exc", {26'd0, wb_exception_o}, 5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fault_squash_2", {31'd0, squash_o}, 0);
        idle(4);

        // Two writers of x3: youngest wins; external squash drops the rest
        expectCommit(3, 32'h1, 32'h400, 0);
        applyStimulus(1, 3, 0, 32'h1, 32'h400, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 32'h2, 32'h404, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        checkOutput("dual_byp_value", byp_ra_o, 32'h2);
        checkOutput("dual_byp_valid", {31'd0, byp_ra_valid_o}, 1);
        checkOutput("dual_x0_byp", {31'd0, byp_rb_valid_o}, 0);
        applyStimulus(1, 4, 0, 32'h4, 32'h408, 0, 0, 0, 1, 0, 0);
        checkOutput("squash_cur_wb", {31'd0, wb_valid_o}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("squash_next_wb", {31'd0, wb_valid_o}, 0);
        idle(4);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        checkOutput("retire_count", retire_count_o, exp_retire);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
